// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/D requesters, the arbiter and the unified memory.
// The arbiter takes the slave view; the requesters and memory model take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req_valid, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    output d_req, d_we, d_addr, d_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and
// data access; D has priority, bounded by a streak counter so IF cannot starve.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_port_arbiter_if.slave       bus,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t            state;
  logic              owner_if;
  logic              drop;
  logic [3:0]        streak;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic win_if;
  logic win_d;
  logic in_idle;
  logic resp_fire;

  function automatic logic [3:0] streak_after_d(input logic [3:0] cur, input logic if_waiting);
    if (!if_waiting)
      return 4'd0;
    else if (cur == STREAK_MAX)
      return cur;
    else
      return cur + 4'd1;
  endfunction

  // A flushed fetch may never win; IF overtakes D once D has used up its streak.
  assign win_if    = bus.if_req && !bus.if_flush && (!bus.d_req || streak == STREAK_MAX);
  assign win_d     = !win_if && bus.d_req;
  assign in_idle   = (state == IDLE);
  assign resp_fire = (state == WAIT) && bus.mem_resp_valid;

  // Grants are gated by reset so nothing is offered while reset is held.
  assign bus.if_gnt    = reset && in_idle && win_if;
  assign bus.d_gnt     = reset && in_idle && win_d;
  assign bus.if_rvalid = resp_fire && owner_if && !drop && !bus.if_flush;
  assign bus.d_rvalid  = resp_fire && !owner_if;
  assign bus.if_rdata  = (resp_fire && owner_if)  ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (resp_fire && !owner_if) ? bus.mem_rdata : '0;

  assign bus.mem_req_valid = (state == ISSUE);
  assign bus.mem_we        = lat_we;
  assign bus.mem_addr      = lat_addr;
  assign bus.mem_wdata     = lat_wdata;
  assign busy              = !in_idle;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner_if  <= 1'b0;
      drop      <= 1'b0;
      streak    <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (win_if) begin
            owner_if  <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= bus.if_addr;
            lat_wdata <= '0;
            streak    <= 4'd0;
            state     <= ISSUE;
          end else if (win_d) begin
            owner_if  <= 1'b0;
            lat_we    <= bus.d_we;
            lat_addr  <= bus.d_addr;
            lat_wdata <= bus.d_wdata;
            streak    <= streak_after_d(streak, bus.if_req);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (owner_if && bus.if_flush)
            drop <= 1'b1;
          if (bus.mem_req_ready)
            state <= WAIT;
        end
        WAIT: begin
          if (owner_if && bus.if_flush)
            drop <= 1'b1;
          if (bus.mem_resp_valid) begin
            drop  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// sequences for starvation bound, delayed flush and asynchronous reset.
module tb_mem_port_arbiter;

  localparam logic        H = 1'b1;
  localparam logic        L = 1'b0;
  localparam logic [31:0] Z = 32'h0;

  logic clk;
  logic reset;
  logic busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MAX_D_STREAK(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required finish before 200000", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        rdy;
    logic        rsp;
    logic [31:0] rdata;
    logic [5:0]  flags;   // {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req_valid, busy}
    logic        chk_rd;
    logic [31:0] e_rdata;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic ir, input logic [31:0] ia, input logic fl,
                     input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                     input logic rdy, input logic rsp, input logic [31:0] rd,
                     input logic [5:0] flags, input logic chk_rd, input logic [31:0] erd,
                     input logic mwe, input logic [31:0] maddr, input logic [31:0] mwdata);
    vec_t v;
    v = '{ir, ia, fl, dr, dw, da, dd, rdy, rsp, rd, flags, chk_rd, erd, mwe, maddr, mwdata};
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = '0;
  endtask

  initial begin
    int    ng;
    logic  got_if[10];
    logic  exp_if[10];

    // Single IF read
    add(H,32'h10,L, L,L,Z,Z, L,L,Z,            6'b100000, L,Z, L,Z,Z);
    add(L,Z,L,      L,L,Z,Z, H,L,Z,            6'b000011, L,Z, L,32'h10,Z);
    add(L,Z,L,      L,L,Z,Z, L,H,32'h00500093, 6'b001001, H,32'h00500093, L,Z,Z);
    add(L,Z,L,      L,L,Z,Z, L,L,Z,            6'b000000, L,Z, L,Z,Z);
    // Simultaneous requests: D write first, IF in the following IDLE
    add(H,32'h40,L, H,H,32'h100,32'hDEADBEEF, L,L,Z, 6'b010000, L,Z, L,Z,Z);
    add(H,32'h40,L, L,L,Z,Z, H,L,Z,            6'b000011, L,Z, H,32'h100,32'hDEADBEEF);
    add(H,32'h40,L, L,L,Z,Z, L,H,32'hAAAA5555, 6'b000101, L,Z, L,Z,Z);
    add(H,32'h40,L, L,L,Z,Z, L,L,Z,            6'b100000, L,Z, L,Z,Z);
    add(L,Z,L,      L,L,Z,Z, H,L,Z,            6'b000011, L,Z, L,32'h40,Z);
    add(L,Z,L,      L,L,Z,Z, L,H,32'h11112222, 6'b001001, H,32'h11112222, L,Z,Z);
    // Backpressure: D read stalled 5 cycles, IF waiting must not be granted
    add(L,Z,L,      H,L,32'h200,Z, L,L,Z,      6'b010000, L,Z, L,Z,Z);
    for (int k = 0; k < 5; k++)
      add(H,32'h300,L, L,L,Z,Z, L,L,Z,         6'b000011, L,Z, L,32'h200,Z);
    add(H,32'h300,L, L,L,Z,Z, H,L,Z,           6'b000011, L,Z, L,32'h200,Z);
    add(H,32'h300,L, L,L,Z,Z, L,H,32'hCAFEF00D,6'b000101, H,32'hCAFEF00D, L,Z,Z);
    add(H,32'h300,L, L,L,Z,Z, L,L,Z,           6'b100000, L,Z, L,Z,Z);
    add(L,Z,L,      L,L,Z,Z, H,L,Z,            6'b000011, L,Z, L,32'h300,Z);
    add(L,Z,L,      L,L,Z,Z, L,H,32'h13579BDF, 6'b001001, H,32'h13579BDF, L,Z,Z);
    add(L,Z,L,      L,L,Z,Z, L,L,Z,            6'b000000, L,Z, L,Z,Z);
    // Flush in IDLE blocks IF; flush in the response cycle suppresses if_rvalid
    add(H,32'h500,H, L,L,Z,Z, L,L,Z,           6'b000000, L,Z, L,Z,Z);
    add(H,32'h500,L, L,L,Z,Z, L,L,Z,           6'b100000, L,Z, L,Z,Z);
    add(L,Z,L,      L,L,Z,Z, H,L,Z,            6'b000011, L,Z, L,32'h500,Z);
    add(L,Z,H,      L,L,Z,Z, L,H,32'h00000077, 6'b000001, L,Z, L,Z,Z);
    add(L,Z,L,      L,L,Z,Z, L,L,Z,            6'b000000, L,Z, L,Z,Z);
    // Flush never touches a D transaction
    add(L,Z,H,      H,L,32'h600,Z, L,L,Z,      6'b010000, L,Z, L,Z,Z);
    add(L,Z,H,      L,L,Z,Z, H,L,Z,            6'b000011, L,Z, L,32'h600,Z);
    add(L,Z,H,      L,L,Z,Z, L,H,32'h600DF00D, 6'b000101, H,32'h600DF00D, L,Z,Z);
    add(L,Z,L,      L,L,Z,Z, L,L,Z,            6'b000000, L,Z, L,Z,Z);

    // Reset state, with requests pending to show grants are held off
    reset = 1'b0;
    drive_idle();
    bus.if_req = 1; bus.d_req = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset busy",      32'(busy),              Z);
    chk("reset mrv",       32'(bus.mem_req_valid), Z);
    chk("reset if_gnt",    32'(bus.if_gnt),        Z);
    chk("reset d_gnt",     32'(bus.d_gnt),         Z);
    chk("reset mem_addr",  bus.mem_addr,           Z);
    chk("reset mem_we",    32'(bus.mem_we),        Z);
    drive_idle();
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.if_req = vecs[i].if_req;   bus.if_addr = vecs[i].if_addr; bus.if_flush = vecs[i].if_flush;
      bus.d_req = vecs[i].d_req;     bus.d_we = vecs[i].d_we;
      bus.d_addr = vecs[i].d_addr;   bus.d_wdata = vecs[i].d_wdata;
      bus.mem_req_ready = vecs[i].rdy; bus.mem_resp_valid = vecs[i].rsp; bus.mem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("row%0d if_gnt", i),    32'(bus.if_gnt),        32'(vecs[i].flags[5]));
      chk($sformatf("row%0d d_gnt", i),     32'(bus.d_gnt),         32'(vecs[i].flags[4]));
      chk($sformatf("row%0d if_rvalid", i), 32'(bus.if_rvalid),     32'(vecs[i].flags[3]));
      chk($sformatf("row%0d d_rvalid", i),  32'(bus.d_rvalid),      32'(vecs[i].flags[2]));
      chk($sformatf("row%0d mrv", i),       32'(bus.mem_req_valid), 32'(vecs[i].flags[1]));
      chk($sformatf("row%0d busy", i),      32'(busy),              32'(vecs[i].flags[0]));
      if (vecs[i].flags[1]) begin
        chk($sformatf("row%0d mem_we", i),    32'(bus.mem_we), 32'(vecs[i].mwe));
        chk($sformatf("row%0d mem_addr", i),  bus.mem_addr,    vecs[i].maddr);
        chk($sformatf("row%0d mem_wdata", i), bus.mem_wdata,   vecs[i].mwdata);
      end
      if (vecs[i].chk_rd && vecs[i].flags[3])
        chk($sformatf("row%0d if_rdata", i), bus.if_rdata, vecs[i].e_rdata);
      if (vecs[i].chk_rd && vecs[i].flags[2])
        chk($sformatf("row%0d d_rdata", i),  bus.d_rdata,  vecs[i].e_rdata);
    end

    // Starvation bound: both requesters always asking, memory always ready
    for (int k = 0; k < 10; k++) exp_if[k] = (k == 4 || k == 9);
    for (int k = 0; k < 10; k++) got_if[k] = 1'b0;
    @(negedge clk);
    drive_idle();
    bus.if_req = 1; bus.if_addr = 32'h800;
    bus.d_req = 1;  bus.d_addr = 32'h900;
    bus.mem_req_ready = 1; bus.mem_resp_valid = 1; bus.mem_rdata = 32'h1;
    ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 10; cyc++) begin
      #1;
      chk("gnt exclusive", 32'(bus.if_gnt & bus.d_gnt), Z);
      if (bus.if_gnt || bus.d_gnt) begin
        got_if[ng] = bus.if_gnt;
        ng++;
      end
      @(negedge clk);
    end
    chk("starve grant count", 32'(ng), 32'd10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("starve grant%0d is_if", k), 32'(got_if[k]), 32'(exp_if[k]));
    bus.if_req = 0; bus.d_req = 0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    drive_idle();
    #1;
    chk("starve drained busy", 32'(busy), Z);

    // Flush during WAIT, response two cycles later is discarded
    @(negedge clk);
    bus.if_req = 1; bus.if_addr = 32'h20;
    #1; chk("flush if_gnt", 32'(bus.if_gnt), 32'd1);
    @(negedge clk);
    bus.if_req = 0; bus.mem_req_ready = 1;
    #1; chk("flush mem_addr", bus.mem_addr, 32'h20);
    @(negedge clk);
    bus.mem_req_ready = 0; bus.if_flush = 1;
    #1; chk("flush pulse rvalid", 32'(bus.if_rvalid), Z);
    @(negedge clk);
    bus.if_flush = 0;
    #1; chk("flush wait busy", 32'(busy), 32'd1);
    @(negedge clk);
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'h12345678;
    #1;
    chk("flush dropped rvalid", 32'(bus.if_rvalid), Z);
    chk("flush resp busy", 32'(busy), 32'd1);
    @(negedge clk);
    bus.mem_resp_valid = 0; bus.mem_rdata = '0;
    bus.if_req = 1; bus.if_addr = 32'h24;
    #1;
    chk("flush back idle", 32'(busy), Z);
    chk("flush next if_gnt", 32'(bus.if_gnt), 32'd1);
    @(negedge clk);
    bus.if_req = 0; bus.mem_req_ready = 1;
    #1; chk("flush next mem_addr", bus.mem_addr, 32'h24);
    @(negedge clk);
    bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'h9ABCDEF0;
    #1;
    chk("flush next rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("flush next rdata", bus.if_rdata, 32'h9ABCDEF0);

    // Asynchronous reset in the middle of WAIT
    @(negedge clk);
    drive_idle();
    bus.d_req = 1; bus.d_addr = 32'h400;
    #1; chk("areset d_gnt", 32'(bus.d_gnt), 32'd1);
    @(negedge clk);
    bus.d_req = 0; bus.mem_req_ready = 1;
    #1; chk("areset issue mrv", 32'(bus.mem_req_valid), 32'd1);
    @(negedge clk);
    bus.mem_req_ready = 0; bus.d_req = 1; bus.d_addr = 32'h404;
    #1; chk("areset in wait", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'h55;
    #1;
    chk("areset busy",     32'(busy),              Z);
    chk("areset mrv",      32'(bus.mem_req_valid), Z);
    chk("areset d_gnt",    32'(bus.d_gnt),         Z);
    chk("areset d_rvalid", 32'(bus.d_rvalid),      Z);
    chk("areset if_rvalid",32'(bus.if_rvalid),     Z);
    chk("areset mem_addr", bus.mem_addr,           Z);
    @(negedge clk);
    reset = 1'b1; bus.d_req = 0;
    #1;
    chk("stale resp d_rvalid",  32'(bus.d_rvalid),  Z);
    chk("stale resp if_rvalid", 32'(bus.if_rvalid), Z);
    chk("stale resp busy",      32'(busy),          Z);
    @(negedge clk);
    bus.mem_resp_valid = 0; bus.d_req = 1;
    #1; chk("post reset d_gnt", 32'(bus.d_gnt), 32'd1);
    @(negedge clk);
    bus.d_req = 0; bus.mem_req_ready = 1;
    #1; chk("post reset mem_addr", bus.mem_addr, 32'h404);
    @(negedge clk);
    bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'h0BADC0DE;
    #1;
    chk("post reset d_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("post reset d_rdata",  bus.d_rdata,       32'h0BADC0DE);
    @(negedge clk);
    drive_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (IF) and the data-access requester (MEM stage, D) of the pipelined CPU.
- Allows one outstanding transaction at a time.
- D has priority, with a bounded-streak rule so that IF cannot starve.
- Supports IF flush: a redirected fetch is completed on the memory side, but its response is discarded.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, maximum consecutive D grants while IF is waiting; range 1..15

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- if_req  input  1  IF request; held with if_addr until if_gnt
- if_addr  input  ADDR_W  fetch address
- if_flush  input  1  discard any IF transaction owned or being granted
- if_gnt  output  1  IF payload sampled this edge
- if_rvalid  output  1  one-cycle fetch response strobe
- if_rdata  output  DATA_W  fetch data, valid with if_rvalid
- d_req  input  1  D request; held with payload until d_gnt
- d_we  input  1  1 = write, 0 = read
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  write data
- d_gnt  output  1  D payload sampled this edge
- d_rvalid  output  1  one-cycle completion strobe (also for writes)
- d_rdata  output  DATA_W  read data, valid with d_rvalid; don't-care for writes
- mem_req_valid  output  1  memory request valid
- mem_req_ready  input  1  memory accepts request
- mem_we  output  1  latched write enable
- mem_addr  output  ADDR_W  latched address
- mem_wdata  output  DATA_W  latched write data
- mem_resp_valid  input  1  memory response/ack
- mem_rdata  input  DATA_W  memory read data
- busy  output  1  state != IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT.
- Reset (reset=0, asynchronous):
  - state = IDLE, owner = D, drop = 0, streak = 0.
  - Latched we/addr/wdata = 0.
  - All outputs 0.
- IDLE:
  - The winner is chosen combinationally.
  - Winner is IF when if_req && !if_flush && (!d_req || streak == MAX_D_STREAK).
  - Otherwise the winner is D if d_req.
  - The winner's gnt is high in the same cycle (combinational).
  - At the edge: latch payload (IF forces we = 0, wdata = 0), latch owner, go to ISSUE.
  - No request: stay in IDLE, no gnt.
- Streak counter, updated at each grant:
  - D grant with if_req high: streak = min(streak + 1, MAX_D_STREAK).
  - D grant with if_req low: streak = 0.
  - IF grant: streak = 0.
- ISSUE:
  - mem_req_valid = 1 with the latched fields.
  - Valid stays asserted and the fields stay stable until mem_req_ready.
  - No abort once in ISSUE.
  - On mem_req_ready: go to WAIT.
  - A mem_resp_valid seen in ISSUE is ignored; memory must not respond before acceptance.
- WAIT:
  - mem_req_valid = 0.
  - On mem_resp_valid, the owner's rvalid is high the same cycle (combinational) and rdata = mem_rdata.
  - Exception: owner = IF with drop set, or if_flush high that cycle; then if_rvalid stays 0.
  - Next state: IDLE.
- Flush:
  - if_flush high in any cycle while owner = IF in ISSUE/WAIT sets drop.
  - drop clears on return to IDLE.
  - if_flush never affects D transactions.
  - if_flush in IDLE blocks IF from winning that cycle.
- Throughput: minimum 3 cycles per transaction (IDLE, ISSUE with ready=1, WAIT with resp=1).
- Requesters may drop req before gnt; nothing is recorded.
- gnt is never asserted outside IDLE.
- if_gnt and d_gnt are never high together.
- rvalid never pulses without a prior gnt.
- Reset mid-transaction: return immediately to IDLE. Outstanding memory responses after reset release are ignored because state is IDLE.
- No address translation or alignment checks; addresses pass through at full width.

Test Plan:
- Single IF read:
  - Stimulus: if_req = 1, if_addr = 0x10; mem ready at once, responds next cycle with 0x00500093.
  - Required: if_gnt in cycle 0; mem_req_valid in cycle 1; if_rvalid with if_rdata = 0x00500093 in cycle 2; busy = 0 in cycle 3.
- Simultaneous requests:
  - Stimulus: if_req and d_req high together; d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF.
  - Required: d_gnt first; mem_we = 1, mem_addr = 0x100; d_rvalid on ack; if_gnt in the following IDLE.
- Starvation bound:
  - Stimulus: MAX_D_STREAK = 4; d_req and if_req held high continuously.
  - Required: grant order D, D, D, D, IF, D, ...; streak resets to 0 after the IF grant.
- Flush:
  - Stimulus: IF granted at 0x20; if_flush pulsed in WAIT; response 0x12345678 arrives 2 cycles later.
  - Required: if_rvalid stays 0; arbiter returns to IDLE; next IF request is served normally.
- Backpressure:
  - Stimulus: mem_req_ready held low for 5 cycles during a D read.
  - Required: mem_req_valid and mem_addr stay stable for all 5 cycles; no extra grants.
- Async reset:
  - Stimulus: reset = 0 asserted mid-WAIT, between clock edges.
  - Required: busy, gnt, rvalid and mem_req_valid go to 0 immediately; a stale mem_resp_valid after release produces no rvalid.
